// File: rtl/input_action_arbiter_pkg.sv
// Shared constants for the action fan-in path.
// Action widths and source-field placement, common to both action arbiters.
package input_action_arbiter_pkg;

    localparam int AXI_CNT_W           = 32;
    localparam int ACT_TDATA_W         = 256;
    localparam int ACT_TUSER_W         = 128;
    localparam int IAA_NUM_QUEUES      = 5;
    localparam int IAA_SRC_PORT_POS    = 16;
    localparam int IAA_SRC_FIELD_W     = IAA_NUM_QUEUES;
    localparam int IAA_PTR_W           = $clog2(IAA_NUM_QUEUES);
    localparam int IAA_FIFO_DEPTH_BITS = 4;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: head entry is visible on dout_o.
// Ports: clk_i/reset_i (sync, high), din_i/wr_en_i, rd_en_i/dout_o,
// nearly_full_o (depth-1 entries), empty_o.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             nearly_full_o,
    output logic             empty_o
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam int CW    = MAX_DEPTH_BITS + 1;

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_q;
    logic [CW-1:0]             cnt_q;
    logic                      do_wr;
    logic                      do_rd;

    assign do_wr         = wr_en_i & (cnt_q != CW'(DEPTH));
    assign do_rd         = rd_en_i & (cnt_q != '0);
    assign empty_o       = (cnt_q == '0);
    assign nearly_full_o = (cnt_q >= CW'(DEPTH - 1));
    assign dout_o        = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/input_action_arbiter_rr_arbiter.sv
// Work-conserving round-robin arbiter with an internal priority pointer.
// Ports: clk_i/rst_i, req_i, advance_i -> grant_o (one-hot), winner_o.
module rr_arbiter #(
    parameter int N     = 5,
    parameter int PTR_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_i,
    input  logic             advance_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] winner_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic             found;
    int               idx;

    // Scan from ptr upward, wrapping; first requester wins.
    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                winner_o     = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) ptr_d = PTR_W'((int'(winner_o) + 1) % N);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/input_action_arbiter.sv
// Merges per-port action streams into one registered master stream.
// Ports: axi_aclk/axi_reset, s_axis_*_0..4 in, m_axis_* out, counters.
module input_action_arbiter
    import input_action_arbiter_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH  = AXI_CNT_W,
    parameter int C_M_ACT_TDATA_WIDTH = ACT_TDATA_W,
    parameter int C_M_ACT_TUSER_WIDTH = ACT_TUSER_W,
    parameter int C_S_ACT_TDATA_WIDTH = ACT_TDATA_W,
    parameter int C_S_ACT_TUSER_WIDTH = ACT_TUSER_W,
    parameter int NUM_QUEUES          = IAA_NUM_QUEUES,
    parameter int SRC_PORT_POS        = IAA_SRC_PORT_POS,
    parameter int FIFO_DEPTH_BITS     = IAA_FIFO_DEPTH_BITS
) (
    input  logic                           axi_aclk,
    input  logic                           axi_reset,
    output logic [C_S_AXI_DATA_WIDTH-1:0]  in_arb_counter,
    output logic [C_S_AXI_DATA_WIDTH-1:0]  in_arb_rd_counter,
    input  logic [C_S_ACT_TDATA_WIDTH-1:0] s_axis_tdata_0,
    input  logic [C_S_ACT_TUSER_WIDTH-1:0] s_axis_tuser_0,
    input  logic                           s_axis_tvalid_0,
    output logic                           s_axis_tready_0,
    input  logic [C_S_ACT_TDATA_WIDTH-1:0] s_axis_tdata_1,
    input  logic [C_S_ACT_TUSER_WIDTH-1:0] s_axis_tuser_1,
    input  logic                           s_axis_tvalid_1,
    output logic                           s_axis_tready_1,
    input  logic [C_S_ACT_TDATA_WIDTH-1:0] s_axis_tdata_2,
    input  logic [C_S_ACT_TUSER_WIDTH-1:0] s_axis_tuser_2,
    input  logic                           s_axis_tvalid_2,
    output logic                           s_axis_tready_2,
    input  logic [C_S_ACT_TDATA_WIDTH-1:0] s_axis_tdata_3,
    input  logic [C_S_ACT_TUSER_WIDTH-1:0] s_axis_tuser_3,
    input  logic                           s_axis_tvalid_3,
    output logic                           s_axis_tready_3,
    input  logic [C_S_ACT_TDATA_WIDTH-1:0] s_axis_tdata_4,
    input  logic [C_S_ACT_TUSER_WIDTH-1:0] s_axis_tuser_4,
    input  logic                           s_axis_tvalid_4,
    output logic                           s_axis_tready_4,
    output logic [C_M_ACT_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [C_M_ACT_TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready
);

    localparam int PW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
    localparam int DW = C_S_ACT_TDATA_WIDTH;
    localparam int UW = C_S_ACT_TUSER_WIDTH;
    localparam int FW = DW + UW;
    localparam int CW = C_S_AXI_DATA_WIDTH;

    logic [DW-1:0]         in_data   [NUM_QUEUES];
    logic [UW-1:0]         in_user   [NUM_QUEUES];
    logic [FW-1:0]         fifo_dout [NUM_QUEUES];
    logic [DW-1:0]         fifo_data [NUM_QUEUES];
    logic [UW-1:0]         fifo_user [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] in_valid;
    logic [NUM_QUEUES-1:0] in_ready;
    logic [NUM_QUEUES-1:0] nearly_full;
    logic [NUM_QUEUES-1:0] empty;
    logic [NUM_QUEUES-1:0] wr_en;
    logic [NUM_QUEUES-1:0] rd_en;
    logic [NUM_QUEUES-1:0] req;
    logic [NUM_QUEUES-1:0] grant;
    logic [PW-1:0]         winner;
    logic                  load;
    logic [UW-1:0]         sel_user;

    logic                           valid_q, valid_d;
    logic [C_M_ACT_TDATA_WIDTH-1:0] data_q, data_d;
    logic [C_M_ACT_TUSER_WIDTH-1:0] user_q, user_d;
    logic [CW-1:0]                  in_cnt_q, in_cnt_d;
    logic [CW-1:0]                  rd_cnt_q, rd_cnt_d;

    assign in_data[0] = s_axis_tdata_0;
    assign in_data[1] = s_axis_tdata_1;
    assign in_data[2] = s_axis_tdata_2;
    assign in_data[3] = s_axis_tdata_3;
    assign in_data[4] = s_axis_tdata_4;
    assign in_user[0] = s_axis_tuser_0;
    assign in_user[1] = s_axis_tuser_1;
    assign in_user[2] = s_axis_tuser_2;
    assign in_user[3] = s_axis_tuser_3;
    assign in_user[4] = s_axis_tuser_4;
    assign in_valid   = {s_axis_tvalid_4, s_axis_tvalid_3,
                         s_axis_tvalid_2, s_axis_tvalid_1,
                         s_axis_tvalid_0};
    assign s_axis_tready_0 = in_ready[0];
    assign s_axis_tready_1 = in_ready[1];
    assign s_axis_tready_2 = in_ready[2];
    assign s_axis_tready_3 = in_ready[3];
    assign s_axis_tready_4 = in_ready[4];

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_fifo
        // Ready stops one entry early so the FIFO can never overflow.
        assign in_ready[g]  = ~nearly_full[g] & ~axi_reset;
        assign wr_en[g]     = in_valid[g] & in_ready[g];
        assign req[g]       = ~empty[g];
        assign fifo_data[g] = fifo_dout[g][DW-1:0];
        assign fifo_user[g] = fifo_dout[g][FW-1:DW];

        fallthrough_small_fifo #(
            .WIDTH          (FW),
            .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clk_i         (axi_aclk),
            .reset_i       (axi_reset),
            .din_i         ({in_user[g], in_data[g]}),
            .wr_en_i       (wr_en[g]),
            .rd_en_i       (rd_en[g]),
            .dout_o        (fifo_dout[g]),
            .nearly_full_o (nearly_full[g]),
            .empty_o       (empty[g])
        );
    end

    assign load  = (~valid_q | m_axis_tready) & (|req);
    assign rd_en = grant & {NUM_QUEUES{load}};

    rr_arbiter #(
        .N     (NUM_QUEUES),
        .PTR_W (PW)
    ) u_rr (
        .clk_i     (axi_aclk),
        .rst_i     (axi_reset),
        .req_i     (req),
        .advance_i (load),
        .grant_o   (grant),
        .winner_o  (winner)
    );

    // Source field is replaced by the one-hot grant.
    always_comb begin
        sel_user = fifo_user[winner];
        sel_user[SRC_PORT_POS +: NUM_QUEUES] = grant;
    end

    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        user_d   = user_q;
        in_cnt_d = in_cnt_q + CW'(|wr_en);
        rd_cnt_d = rd_cnt_q + CW'(load);
        if (load) begin
            valid_d = 1'b1;
            data_d  = fifo_data[winner];
            user_d  = sel_user;
        end else if (m_axis_tready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            user_q   <= '0;
            in_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            user_q   <= user_d;
            in_cnt_q <= in_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign m_axis_tvalid     = valid_q;
    assign m_axis_tdata      = data_q;
    assign m_axis_tuser      = user_q;
    assign in_arb_counter    = in_cnt_q;
    assign in_arb_rd_counter = rd_cnt_q;

endmodule

// File: tb/tb_input_action_arbiter.sv
// Scoreboard bench for input_action_arbiter.
// Per-port expected queues plus an optional expected source order.
module tb_input_action_arbiter;

    localparam int NQ  = 5;
    localparam int DW  = 256;
    localparam int UW  = 128;
    localparam int POS = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [UW-1:0] u;
    } act_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata [NQ];
    logic [UW-1:0] s_tuser [NQ];
    logic [NQ-1:0] s_tvalid = '0;
    logic [NQ-1:0] s_tready;
    logic [DW-1:0] m_tdata;
    logic [UW-1:0] m_tuser;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic [31:0]   cnt_in;
    logic [31:0]   cnt_rd;

    act_t pq [NQ][$];
    int   src_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   exp_in     = 0;
    int   exp_rd     = 0;

    logic          stall_prev = 1'b0;
    logic [DW-1:0] hold_d;
    logic [UW-1:0] hold_u;

    always #5 clk = ~clk;

    input_action_arbiter dut (
        .axi_aclk          (clk),
        .axi_reset         (rst),
        .in_arb_counter    (cnt_in),
        .in_arb_rd_counter (cnt_rd),
        .s_axis_tdata_0    (s_tdata[0]),
        .s_axis_tuser_0    (s_tuser[0]),
        .s_axis_tvalid_0   (s_tvalid[0]),
        .s_axis_tready_0   (s_tready[0]),
        .s_axis_tdata_1    (s_tdata[1]),
        .s_axis_tuser_1    (s_tuser[1]),
        .s_axis_tvalid_1   (s_tvalid[1]),
        .s_axis_tready_1   (s_tready[1]),
        .s_axis_tdata_2    (s_tdata[2]),
        .s_axis_tuser_2    (s_tuser[2]),
        .s_axis_tvalid_2   (s_tvalid[2]),
        .s_axis_tready_2   (s_tready[2]),
        .s_axis_tdata_3    (s_tdata[3]),
        .s_axis_tuser_3    (s_tuser[3]),
        .s_axis_tvalid_3   (s_tvalid[3]),
        .s_axis_tready_3   (s_tready[3]),
        .s_axis_tdata_4    (s_tdata[4]),
        .s_axis_tuser_4    (s_tuser[4]),
        .s_axis_tvalid_4   (s_tvalid[4]),
        .s_axis_tready_4   (s_tready[4]),
        .m_axis_tdata      (m_tdata),
        .m_axis_tuser      (m_tuser),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tready     (m_tready)
    );

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [UW-1:0] stamp(logic [UW-1:0] u, int p);
        logic [UW-1:0] r;
        r = u;
        r[POS +: NQ] = NQ'(1 << p);
        return r;
    endfunction

    function automatic int pending();
        int n;
        n = 0;
        for (int i = 0; i < NQ; i++) n += pq[i].size();
        return n;
    endfunction

    // Monitor: record accepted inputs, check every issued output.
    always @(negedge clk) begin
        logic          any;
        logic [NQ-1:0] src;
        int            s;
        act_t          a;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            any = 1'b0;
            for (int i = 0; i < NQ; i++) begin
                if (s_tvalid[i] && s_tready[i]) begin
                    pq[i].push_back({s_tdata[i], stamp(s_tuser[i], i)});
                    any = 1'b1;
                end
            end
            if (any) exp_in++;
            if (stall_prev) begin
                chk("hold_valid", DW'(m_tvalid), DW'(1));
                chk("hold_data", m_tdata, hold_d);
                chk("hold_user", DW'(m_tuser), DW'(hold_u));
            end
            stall_prev = m_tvalid && !m_tready;
            hold_d = m_tdata;
            hold_u = m_tuser;
            if (m_tvalid && m_tready) begin
                exp_rd++;
                src = m_tuser[POS +: NQ];
                s = -1;
                for (int i = 0; i < NQ; i++)
                    if (src == NQ'(1 << i)) s = i;
                if (s < 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL src_onehot: got %b expected one-hot", src);
                end else begin
                    if (src_q.size() > 0)
                        chk("order_src", DW'(s), DW'(src_q.pop_front()));
                    if (pq[s].size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL extra_out: got port %0d expected none", s);
                    end else begin
                        a = pq[s].pop_front();
                        chk("out_data", m_tdata, a.d);
                        chk("out_user", DW'(m_tuser), DW'(a.u));
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst      = 1'b1;
        s_tvalid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < NQ; i++) pq[i].delete();
        src_q.delete();
        exp_in = 0;
        exp_rd = 0;
        rst    = 1'b0;
    endtask

    function automatic logic [DW-1:0] mkdata(int p, int seq, bit rnd);
        logic [DW-1:0] d;
        d = {(DW/8){8'hA5}} ^ DW'(p * 256 + seq);
        if (rnd)
            for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [UW-1:0] mkuser(int seq, bit rnd);
        logic [UW-1:0] u;
        u = ~UW'(seq);
        if (rnd)
            for (int k = 0; k < UW / 32; k++) u[k*32 +: 32] = $urandom;
        return u;
    endfunction

    // Offers nper actions per masked port; waits on each handshake.
    task automatic stream(logic [NQ-1:0] mask, int nper, bit rnd, bit tog);
        int            sent [NQ];
        logic [NQ-1:0] hs;
        bit            done;
        for (int i = 0; i < NQ; i++) sent[i] = 0;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            for (int i = 0; i < NQ; i++) begin
                if (mask[i] && !s_tvalid[i] && sent[i] < nper &&
                    (!rnd || $urandom_range(0, 1) == 1)) begin
                    s_tdata[i]  = mkdata(i, sent[i], rnd);
                    s_tuser[i]  = mkuser(sent[i], rnd);
                    s_tvalid[i] = 1'b1;
                end
            end
            @(negedge clk);
            hs = s_tvalid & s_tready;
            @(posedge clk); #1;
            for (int i = 0; i < NQ; i++) begin
                if (hs[i]) begin
                    sent[i]++;
                    s_tvalid[i] = 1'b0;
                end
            end
            if (tog) m_tready = ~m_tready;
            done = 1'b1;
            for (int i = 0; i < NQ; i++)
                if (mask[i] && sent[i] < nper) done = 1'b0;
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL stream_timeout: got unfinished expected done");
        end
    endtask

    task automatic drain(string nm);
        int n;
        m_tready = 1'b1;
        n = 0;
        while ((m_tvalid || pending() > 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_leftover"}, DW'(pending()), DW'(0));
        chk({nm, "_order_left"}, DW'(src_q.size()), DW'(0));
        chk({nm, "_in_cnt"}, DW'(cnt_in), DW'(exp_in));
        chk({nm, "_rd_cnt"}, DW'(cnt_rd), DW'(exp_rd));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            acc;
        logic          hs;
        logic [DW-1:0] first_d;

        for (int i = 0; i < NQ; i++) begin
            s_tdata[i] = '0;
            s_tuser[i] = '0;
        end

        // Reset state
        @(posedge clk); #1;
        chk("rst_valid", DW'(m_tvalid), DW'(0));
        chk("rst_data", m_tdata, '0);
        chk("rst_user", DW'(m_tuser), DW'(0));
        chk("rst_in_cnt", DW'(cnt_in), DW'(0));
        chk("rst_rd_cnt", DW'(cnt_rd), DW'(0));
        chk("rst_tready", DW'(s_tready), DW'(0));
        do_reset();

        // Single action on port 2, latency and source field
        m_tready    = 1'b1;
        s_tdata[2]  = {(DW/8){8'hA5}};
        s_tuser[2]  = '0;
        s_tvalid[2] = 1'b1;
        src_q.push_back(2);
        @(negedge clk);
        chk("t1_ready2", DW'(s_tready[2]), DW'(1));
        @(posedge clk); #1;
        s_tvalid[2] = 1'b0;
        chk("t1_valid_n1", DW'(m_tvalid), DW'(0));
        @(posedge clk); #1;
        chk("t1_valid_n2", DW'(m_tvalid), DW'(1));
        chk("t1_src", DW'(m_tuser[POS +: NQ]), DW'(5'b00100));
        chk("t1_in_cnt", DW'(cnt_in), DW'(1));
        chk("t1_rd_cnt", DW'(cnt_rd), DW'(1));
        @(posedge clk); #1;
        chk("t1_valid_clr", DW'(m_tvalid), DW'(0));
        drain("t1");

        // All ports at once: order 0..4, pointer returns to 0
        do_reset();
        for (int i = 0; i < NQ; i++) src_q.push_back(i);
        stream(5'b11111, 1, 1'b0, 1'b0);
        drain("t2");
        chk("t2_in_cnt_hand", DW'(cnt_in), DW'(1));
        chk("t2_rd_cnt_hand", DW'(cnt_rd), DW'(5));
        src_q.push_back(0);
        src_q.push_back(4);
        stream(5'b10001, 1, 1'b0, 1'b0);
        drain("t2b");

        // Ports 1 and 3 streaming: strict alternation
        do_reset();
        for (int k = 0; k < 10; k++) begin
            src_q.push_back(1);
            src_q.push_back(3);
        end
        stream(5'b01010, 10, 1'b0, 1'b0);
        drain("t3");
        chk("t3_rd_cnt_hand", DW'(cnt_rd), DW'(20));

        // Back-pressure: output held, FIFO fills to depth-1
        do_reset();
        m_tready    = 1'b0;
        first_d     = mkdata(0, 0, 1'b0);
        s_tdata[0]  = first_d;
        s_tuser[0]  = mkuser(0, 1'b0);
        s_tvalid[0] = 1'b1;
        acc = 0;
        for (int c = 0; c < 120 && acc < 20; c++) begin
            @(negedge clk);
            hs = s_tvalid[0] & s_tready[0];
            if (c == 39) begin
                chk("t4_ready0_low", DW'(s_tready[0]), DW'(0));
                chk("t4_fifo_held", DW'(acc - 1), DW'(15));
                chk("t4_head", m_tdata, first_d);
            end
            @(posedge clk); #1;
            if (hs) begin
                acc++;
                if (acc < 20) begin
                    s_tdata[0] = mkdata(0, acc, 1'b0);
                    s_tuser[0] = mkuser(acc, 1'b0);
                end else begin
                    s_tvalid[0] = 1'b0;
                end
            end
            if (c == 39) m_tready = 1'b1;
        end
        s_tvalid[0] = 1'b0;
        drain("t4");
        chk("t4_rd_cnt_hand", DW'(cnt_rd), DW'(20));

        // Random traffic with toggling ready
        do_reset();
        m_tready = 1'b1;
        stream(5'b11111, 12, 1'b1, 1'b1);
        drain("t5");
        chk("t5_rd_cnt_hand", DW'(cnt_rd), DW'(60));

        // Reset with 7 actions buffered
        do_reset();
        m_tready = 1'b0;
        stream(5'b11111, 1, 1'b0, 1'b0);
        stream(5'b00011, 1, 1'b0, 1'b0);
        chk("t6_buffered", DW'(pending()), DW'(7));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_valid", DW'(m_tvalid), DW'(0));
        chk("t6_in_cnt", DW'(cnt_in), DW'(0));
        chk("t6_rd_cnt", DW'(cnt_rd), DW'(0));
        chk("t6_tready_rst", DW'(s_tready), DW'(0));
        for (int i = 0; i < NQ; i++) pq[i].delete();
        exp_in   = 0;
        exp_rd   = 0;
        rst      = 1'b0;
        m_tready = 1'b1;
        @(posedge clk); #1;
        chk("t6_tready_after", DW'(s_tready), DW'(5'b11111));
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_valid_after", DW'(m_tvalid), DW'(0));
        chk("t6_rd_after", DW'(cnt_rd), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
